// File: rtl/mem_responder.sv
// mem_responder: 8-bit bus memory target; ports clk, rst, memory_data_bus (inout), memory_address_bus, memory_enable, memory_write_enable, busy, bus_error (only with MEM_BUS_ERR_EN)
module mem_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] memory_data_bus,
  input  logic [15:0]           memory_address_bus,
  input  logic                  memory_enable,
  input  logic                  memory_write_enable,
  output logic                  busy
`ifdef MEM_BUS_ERR_EN
  ,
  output logic                  bus_error
`endif
);
  typedef enum logic [1:0] {CLEAR, IDLE, ACK_R, ACK_W} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr, mem_addr;
  logic [DATA_WIDTH-1:0] rd_data_q, mem_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic drive_en_q, drive_en_d, mem_we, rd_en, addr_ok, last;
  assign addr = memory_address_bus[ADDR_WIDTH-1:0];
  assign last = cnt_q == ADDR_WIDTH'(DEPTH - 1);
  assign busy = state_q == CLEAR;
  assign memory_data_bus = drive_en_q ? rd_data_q : {DATA_WIDTH{1'bz}};
`ifdef MEM_BUS_ERR_EN
  logic bus_error_q, bus_error_d;
  assign addr_ok = ~|memory_address_bus[15:ADDR_WIDTH];
  assign bus_error = bus_error_q;
  assign bus_error_d = bus_error_q | (state_q == IDLE && memory_enable && !addr_ok);
  always_ff @(posedge clk)
    bus_error_q <= rst ? 1'b0 : bus_error_d;
`else
  logic unused_hi;
  assign unused_hi = ^memory_address_bus[15:ADDR_WIDTH];
  assign addr_ok = 1'b1;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drive_en_d = 1'b0;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    mem_addr   = addr;
    mem_wdata  = memory_data_bus;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = last ? cnt_q : cnt_q + 1'b1;
        state_d   = last ? IDLE : CLEAR;
      end
      IDLE: if (memory_enable) begin
        state_d    = memory_write_enable ? ACK_W : ACK_R;
        mem_we     = memory_write_enable & addr_ok;
        rd_en      = ~memory_write_enable & addr_ok;
        drive_en_d = rd_en;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q      <= '0;
      drive_en_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drive_en_q <= drive_en_d;
      if (rd_en) rd_data_q <= mem[addr];
    end
  end
  always_ff @(posedge clk)
    if (mem_we && !rst) mem[mem_addr] <= mem_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against an array reference model
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, wen = 1'b0, tb_oe = 1'b0, chk_rd = 1'b0, busy;
  logic [15:0] adr = '0;
  logic [7:0] tb_drv = '0;
  wire  [7:0] bus;
  int errs = 0, checks = 0;
  logic [7:0] ref_mem [1024];
  logic [7:0] exp_q [$];
  logic exp_err = 1'b0;
  assign bus = tb_oe ? tb_drv : 8'bz;
  always #5 clk = ~clk;
`ifdef MEM_BUS_ERR_EN
  logic bus_error;
  mem_responder dut (.clk(clk), .rst(rst), .memory_data_bus(bus), .memory_address_bus(adr),
    .memory_enable(en), .memory_write_enable(wen), .busy(busy), .bus_error(bus_error));
`else
  mem_responder dut (.clk(clk), .rst(rst), .memory_data_bus(bus), .memory_address_bus(adr),
    .memory_enable(en), .memory_write_enable(wen), .busy(busy));
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_rd) begin
    if (exp_q.size() == 0) chk("read_unexpected", 32'(bus), 32'hx);
    else chk("read_data", 32'(bus), 32'(exp_q.pop_front()));
  end
  task automatic clear_model();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask
  task automatic sweep_len(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask
  task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d, input bit ign);
    bit ok;
    int idx;
    idx = int'(a[9:0]);
`ifdef MEM_BUS_ERR_EN
    ok = a[15:10] == 6'd0;
`else
    ok = 1'b1;
`endif
    en = 1'b1; wen = we; adr = a; tb_oe = we; tb_drv = d;
    @(posedge clk); #1;
    if (!ign) begin
      if (!ok) exp_err = 1'b1;
      else if (we) ref_mem[idx] = d;
      else begin
        exp_q.push_back(ref_mem[idx]);
        chk_rd = 1'b1;
      end
    end
    tb_drv = ~d;
    @(posedge clk); #1;
    chk_rd = 1'b0; en = 1'b0; tb_oe = 1'b0;
  endtask
  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [15:0] a;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    sweep_len(n);
    chk("sweep_len", n, 1024);
    chk("busy_after_sweep", 32'(busy), 0);
`ifdef MEM_BUS_ERR_EN
    chk("bus_error_reset", 32'(bus_error), 0);
`endif
    access(0, 16'h000, 0, 0);
    access(0, 16'h1FF, 0, 0);
    access(0, 16'h3FF, 0, 0);
    access(1, 16'h012, 8'hA5, 0);
    access(0, 16'h012, 0, 0);
    access(1, 16'h001, 8'h11, 0);
    access(1, 16'h002, 8'h22, 0);
    access(0, 16'h001, 0, 0);
    access(0, 16'h002, 0, 0);
    access(1, 16'h0412, 8'h3C, 0);
    access(0, 16'h012, 0, 0);
`ifdef MEM_BUS_ERR_EN
    chk("bus_error_oor", 32'(bus_error), 1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    clear_model();
    chk("busy_reset2", 32'(busy), 1);
    access(1, 16'h005, 8'h77, 1);
    access(1, 16'h3FF, 8'h77, 1);
    sweep_len(n);
    chk("busy_fall2", 32'(busy), 0);
    access(0, 16'h005, 0, 0);
    access(0, 16'h3FF, 0, 0);
    access(1, 16'h020, 8'h5A, 0);
    en = 1'b1; wen = 1'b0; adr = 16'h020;
    @(posedge clk); #1;
    exp_q.push_back(ref_mem[32]);
    chk_rd = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk_rd = 1'b0; rst = 1'b0; en = 1'b0;
    exp_err = 1'b0;
    clear_model();
    chk("busy_mid_read_rst", 32'(busy), 1);
    sweep_len(n);
    chk("sweep_len_restart", n, 1024);
    access(0, 16'h020, 0, 0);
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      access(1'($urandom), a, 8'($urandom), 0);
    end
    for (int i = 0; i < 16; i++) access(0, 16'(i), 0, 0);
    chk("queue_empty", exp_q.size(), 0);
`ifdef MEM_BUS_ERR_EN
    chk("bus_error_final", 32'(bus_error), 32'(exp_err));
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
